pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard and sequencing controller for the IF/ID/EX/WB integer pipeline.
//  Tracks in-flight register writes in a shadow copy of the EX and WB stages and detects RAW hazards against ID sources.
//  Gates the PC and IF_ID enables and injects bubbles into ID_EX.
//  Adds boot-hold, halt/drain and resume sequencing, plus a saturating stall counter.
// PARAMETERS
//  REG_AW    5  register address width
//  BOOT_CYC  2  cycles PC/IF_ID held after reset release (IMEM settle), 1..15
//  WB_BYPASS 0  1 = reg_file is write-through, so a WB-stage match is not a hazard
//  CNT_W     16 stall counter width
// PORTS
//  clk          in  1      pipeline clock, rising edge
//  rst          in  1      asynchronous reset, active-low
//  id_valid     in  1      ID holds a real instruction
//  id_rs1       in  REG_AW ID source 1 (instr[19:15])
//  id_rs2       in  REG_AW ID source 2 (instr[24:20])
//  id_use_rs1   in  1      instruction reads rs1
//  id_use_rs2   in  1      instruction reads rs2
//  id_regwrite  in  1      main_control RegWrite for ID instruction
//  id_rd        in  REG_AW ID destination (instr[11:7])
//  halt_req     in  1      level; request drain and halt
//  resume       in  1      pulse; leave HALT
//  pc_en        out 1      PC load enable
//  ifid_en      out 1      IF_ID load enable
//  idex_bubble  out 1      force ID_EX RegWrite=0 (NOP) this cycle
//  stall        out 1      RAW hazard stall active
//  halted       out 1      FSM in HALT, pipeline empty
//  stall_cnt    out CNT_W  saturating count of hazard-stall cycles
// BEHAVIOUR
//  Reset (rst=0, async): state=BOOT, boot counter=0, shadow EX/WB valid=0, stall_cnt=0.
//   Outputs during reset: pc_en=0, ifid_en=0, idex_bubble=1, stall=0, halted=0.
//  Shadow stage entry = {valid, regwrite, rd}.
//   A match needs valid & regwrite & rd!=0 & rd==src & use_src.
//  hazard (comb) = id_valid & (match vs EX | (~WB_BYPASS & match vs WB)).
//  issue = (state==RUN) & id_valid & ~hazard.
//  Each posedge: EX <= issue ? {1,id_regwrite,id_rd} : 0; WB <= EX.
//  FSM states:
//   BOOT: pc_en=ifid_en=0, bubble=1. Count to BOOT_CYC-1, then go to RUN.
//   RUN: stall=hazard. pc_en=ifid_en=~hazard; bubble=hazard|~id_valid.
//    If halt_req=1, go to DRAIN; the current cycle still completes as RUN.
//   DRAIN: pc_en=ifid_en=0, bubble=1, stall=0.
//    When EX.valid=0 and WB.valid=0 (shadow), go to HALT.
//   HALT: same gating as DRAIN, halted=1. resume=1 goes to RUN; halt_req is ignored in HALT.
//  Hazard stall lasts at most 2 cycles (1 if WB_BYPASS).
//   The ID instruction and fetched IF word are held; no instruction is lost or duplicated.
//  Simultaneous halt_req and hazard in RUN: the stall is honoured that cycle.
//   DRAIN next; the held ID instruction re-issues after resume.
//  resume and halt_req both high in HALT: go to RUN. halt_req seen again next cycle gives DRAIN.
//  stall_cnt increments on every RUN cycle with hazard=1 and saturates at all-ones.
//  Writes or reads of x0 never cause a hazard.
//  Reset mid-operation (any state): immediate return to reset values; BOOT restarts.
// TESTING
//  1. Reset, BOOT_CYC=2: pc_en=0 for 2 cycles after rst rises, then 1; halted=0, stall_cnt=0.
//  2. addi x5 then add x6,x5,x1 back-to-back: stall=1 for 2 cycles, bubble=1, pc_en=0.
//     Then issue; stall_cnt=2. With WB_BYPASS=1: 1 cycle, stall_cnt=1.
//  3. Producer rd=x0, consumer reads x0: stall never asserts; one independent op between: 1-cycle stall.
//  4. halt_req pulsed with 2 instrs in flight: DRAIN for 2 cycles, then halted=1.
//     pc_en stays 0 until resume; one cycle after resume, pc_en=1.
//  5. halt_req in same cycle as hazard: stall honoured, DRAIN entered.
//     After resume the held instruction issues exactly once (check the EX shadow).
//  6. CNT_W=2, 5 hazard cycles: stall_cnt=3 (saturated). rst low mid-DRAIN: all outputs at reset values at once.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the IF/ID/EX/WB integer pipeline.
// Keeps a shadow of the EX and WB destination registers, stalls ID on RAW
// hazards, and sequences boot-hold, halt/drain and resume of the pipeline.

module pipe_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int BOOT_CYC  = 2,
  parameter bit WB_BYPASS = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_regwrite,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              halt_req,
  input  logic              resume,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_bubble,
  output logic              stall,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYC - 1);

  state_t state, next_state;
  logic [3:0] boot_cnt;

  logic              ex_valid, ex_regwrite;
  logic [REG_AW-1:0] ex_rd;
  logic              wb_valid, wb_regwrite;
  logic [REG_AW-1:0] wb_rd;

  logic ex_live, wb_live;
  logic match_ex, match_wb;
  logic hazard, issue;

  // Match ID sources against the shadow stages; x0 is never a real dependency.
  always_comb begin
    ex_live  = ex_valid & ex_regwrite & (ex_rd != '0);
    wb_live  = wb_valid & wb_regwrite & (wb_rd != '0);
    match_ex = ex_live & ((id_use_rs1 & (ex_rd == id_rs1)) |
                          (id_use_rs2 & (ex_rd == id_rs2)));
    match_wb = wb_live & ((id_use_rs1 & (wb_rd == id_rs1)) |
                          (id_use_rs2 & (wb_rd == id_rs2)));
    hazard   = id_valid & (match_ex | (~WB_BYPASS & match_wb));
    issue    = (state == ST_RUN) & id_valid & ~hazard;
  end

  // Advance the shadow pipeline: a bubble enters EX whenever nothing issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_rd       <= '0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
    end else begin
      ex_valid    <= issue;
      ex_regwrite <= issue & id_regwrite;
      ex_rd       <= issue ? id_rd : '0;
      wb_valid    <= ex_valid;
      wb_regwrite <= ex_regwrite;
      wb_rd       <= ex_rd;
    end
  end

  // Boot-hold counter runs only while in BOOT so every reset restarts the hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      boot_cnt <= '0;
    end else if (state == ST_BOOT) begin
      boot_cnt <= boot_cnt + 4'd1;
    end else begin
      boot_cnt <= '0;
    end
  end

  // Saturating count of RUN cycles lost to a RAW hazard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if ((state == ST_RUN) && hazard && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_BOOT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: halt_req only matters in RUN, resume only in HALT.
  always_comb begin
    next_state = state;
    case (state)
      ST_BOOT:  if (boot_cnt == BOOT_LAST) next_state = ST_RUN;
      ST_RUN:   if (halt_req) next_state = ST_DRAIN;
      ST_DRAIN: if (!ex_valid && !wb_valid) next_state = ST_HALT;
      ST_HALT:  if (resume) next_state = ST_RUN;
      default:  next_state = ST_BOOT;
    endcase
  end

  // Output decode: everything outside RUN freezes fetch and feeds bubbles.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_bubble = 1'b1;
    stall       = 1'b0;
    halted      = 1'b0;
    case (state)
      ST_RUN: begin
        stall       = hazard;
        pc_en       = ~hazard;
        ifid_en     = ~hazard;
        idex_bubble = hazard | ~id_valid;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one DUT with default parameters and a
// second with WB_BYPASS=1 and a 2-bit stall counter, sharing the ID inputs.

module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       rst_b;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       id_regwrite;
  logic [4:0] id_rd;
  logic       halt_req;
  logic       resume;

  logic        pc_en, ifid_en, idex_bubble, stall, halted;
  logic [15:0] stall_cnt;
  logic        pc_en_b, ifid_en_b, idex_bubble_b, stall_b, halted_b;
  logic [1:0]  stall_cnt_b;

  int n_assert;
  int n_fail;

  pipe_hazard_ctrl #(.REG_AW(5), .BOOT_CYC(2), .WB_BYPASS(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_regwrite(id_regwrite), .id_rd(id_rd),
    .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_bubble(idex_bubble),
    .stall(stall), .halted(halted), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .BOOT_CYC(2), .WB_BYPASS(1'b1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_b),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_regwrite(id_regwrite), .id_rd(id_rd),
    .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en_b), .ifid_en(ifid_en_b), .idex_bubble(idex_bubble_b),
    .stall(stall_b), .halted(halted_b), .stall_cnt(stall_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of ID/control inputs just after the falling edge.
  task automatic applyStimulus(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                               input logic u1, input logic u2, input logic rw,
                               input logic [4:0] rd, input logic h, input logic rs);
    @(negedge clk);
    id_valid    = v;
    id_rs1      = r1;
    id_rs2      = r2;
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    id_regwrite = rw;
    id_rd       = rd;
    halt_req    = h;
    resume      = rs;
    #1;
  endtask

  task automatic checkVal(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare all outputs of one DUT (sel_b picks the bypass instance).
  task automatic checkOutput(input string tag, input bit sel_b, input int e_pc,
                             input int e_bub, input int e_stall, input int e_halt,
                             input int e_cnt);
    if (sel_b) begin
      checkVal({tag, ".pc_en"},  int'(pc_en_b),       e_pc);
      checkVal({tag, ".ifid_en"}, int'(ifid_en_b),    e_pc);
      checkVal({tag, ".bubble"}, int'(idex_bubble_b), e_bub);
      checkVal({tag, ".stall"},  int'(stall_b),       e_stall);
      checkVal({tag, ".halted"}, int'(halted_b),      e_halt);
      checkVal({tag, ".cnt"},    int'(stall_cnt_b),   e_cnt);
    end else begin
      checkVal({tag, ".pc_en"},  int'(pc_en),       e_pc);
      checkVal({tag, ".ifid_en"}, int'(ifid_en),    e_pc);
      checkVal({tag, ".bubble"}, int'(idex_bubble), e_bub);
      checkVal({tag, ".stall"},  int'(stall),       e_stall);
      checkVal({tag, ".halted"}, int'(halted),      e_halt);
      checkVal({tag, ".cnt"},    int'(stall_cnt),   e_cnt);
    end
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst         = 1'b0;
    rst_b       = 1'b0;
    id_valid    = 1'b0;
    id_rs1      = '0;
    id_rs2      = '0;
    id_use_rs1  = 1'b0;
    id_use_rs2  = 1'b0;
    id_regwrite = 1'b0;
    id_rd       = '0;
    halt_req    = 1'b0;
    resume      = 1'b0;

    // Reset values and boot hold
    #1;
    checkOutput("reset", 1'b0, 0, 1, 0, 0, 0);
    checkOutput("reset_b", 1'b1, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    checkOutput("boot0", 1'b0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("boot1", 1'b0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("run0", 1'b0, 1, 1, 0, 0, 0);

    // addi x5,x1 ; add x6,x5,x1 -> two stall cycles
    applyStimulus(1, 1, 0, 1, 0, 1, 5, 0, 0);
    checkOutput("t2_prod", 1'b0, 1, 0, 0, 0, 0);
    applyStimulus(1, 5, 1, 1, 1, 1, 6, 0, 0);
    checkOutput("t2_stall1", 1'b0, 0, 1, 1, 0, 0);
    applyStimulus(1, 5, 1, 1, 1, 1, 6, 0, 0);
    checkOutput("t2_stall2", 1'b0, 0, 1, 1, 0, 1);
    applyStimulus(1, 5, 1, 1, 1, 1, 6, 0, 0);
    checkOutput("t2_issue", 1'b0, 1, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_idle", 1'b0, 1, 1, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_idle2", 1'b0, 1, 1, 0, 0, 2);

    // x0 never hazards; one independent op between gives one stall cycle
    applyStimulus(1, 1, 0, 1, 0, 1, 0, 0, 0);
    checkOutput("t3_x0prod", 1'b0, 1, 0, 0, 0, 2);
    applyStimulus(1, 0, 0, 1, 1, 1, 10, 0, 0);
    checkOutput("t3_x0cons", 1'b0, 1, 0, 0, 0, 2);
    applyStimulus(1, 1, 0, 1, 0, 1, 7, 0, 0);
    checkOutput("t3_prod", 1'b0, 1, 0, 0, 0, 2);
    applyStimulus(1, 2, 3, 1, 1, 1, 8, 0, 0);
    checkOutput("t3_indep", 1'b0, 1, 0, 0, 0, 2);
    applyStimulus(1, 7, 0, 1, 0, 1, 11, 0, 0);
    checkOutput("t3_stall", 1'b0, 0, 1, 1, 0, 2);
    applyStimulus(1, 7, 0, 1, 0, 1, 11, 0, 0);
    checkOutput("t3_issue", 1'b0, 1, 0, 0, 0, 3);

    // Halt with two instructions in flight
    applyStimulus(1, 1, 0, 1, 0, 1, 12, 0, 0);
    checkOutput("t4_a", 1'b0, 1, 0, 0, 0, 3);
    applyStimulus(1, 2, 0, 1, 0, 1, 13, 0, 0);
    checkOutput("t4_b", 1'b0, 1, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("t4_halt", 1'b0, 1, 1, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_drain1", 1'b0, 0, 1, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_drain2", 1'b0, 0, 1, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_halted", 1'b0, 0, 1, 0, 1, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("t4_halted_hr", 1'b0, 0, 1, 0, 1, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("t4_resume", 1'b0, 0, 1, 0, 1, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_run", 1'b0, 1, 1, 0, 0, 3);

    // Halt request coinciding with a hazard; held instruction issues once
    applyStimulus(1, 1, 0, 1, 0, 1, 9, 0, 0);
    checkOutput("t5_prod", 1'b0, 1, 0, 0, 0, 3);
    applyStimulus(1, 4, 9, 1, 1, 1, 14, 1, 0);
    checkOutput("t5_stall_halt", 1'b0, 0, 1, 1, 0, 3);
    applyStimulus(1, 4, 9, 1, 1, 1, 14, 0, 0);
    checkOutput("t5_drain1", 1'b0, 0, 1, 0, 0, 4);
    applyStimulus(1, 4, 9, 1, 1, 1, 14, 0, 0);
    checkOutput("t5_drain2", 1'b0, 0, 1, 0, 0, 4);
    applyStimulus(1, 4, 9, 1, 1, 1, 14, 0, 0);
    checkOutput("t5_halted", 1'b0, 0, 1, 0, 1, 4);
    applyStimulus(1, 4, 9, 1, 1, 1, 14, 0, 1);
    checkOutput("t5_resume", 1'b0, 0, 1, 0, 1, 4);
    checkVal("t5_ex_empty", int'(dut.ex_valid), 0);
    applyStimulus(1, 4, 9, 1, 1, 1, 14, 0, 0);
    checkOutput("t5_issue", 1'b0, 1, 0, 0, 0, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkVal("t5_ex_valid", int'(dut.ex_valid), 1);
    checkVal("t5_ex_rd", int'(dut.ex_rd), 14);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkVal("t5_ex_once", int'(dut.ex_valid), 0);

    // resume and halt_req together in HALT
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("t7_run_halt", 1'b0, 1, 1, 0, 0, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("t7_drain", 1'b0, 0, 1, 0, 0, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("t7_halt_both", 1'b0, 0, 1, 0, 1, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("t7_run", 1'b0, 1, 1, 0, 0, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t7_drain_again", 1'b0, 0, 1, 0, 0, 4);

    // Asynchronous reset in the middle of DRAIN
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t8_halt", 1'b0, 0, 1, 0, 1, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("t8_resume", 1'b0, 0, 1, 0, 1, 4);
    applyStimulus(1, 1, 0, 1, 0, 1, 15, 1, 0);
    checkOutput("t8_issue_halt", 1'b0, 1, 0, 0, 0, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t8_drain", 1'b0, 0, 1, 0, 0, 4);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t8_rst", 1'b0, 0, 1, 0, 0, 0);
    checkVal("t8_rst_ex", int'(dut.ex_valid), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    checkOutput("t8_boot0", 1'b0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t8_boot1", 1'b0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t8_run", 1'b0, 1, 1, 0, 0, 0);

    // Bypass instance: one-cycle stall, then saturation of the 2-bit counter
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_b = 1'b1;
    checkOutput("b_boot0", 1'b1, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("b_boot1", 1'b1, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("b_run", 1'b1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 1, 5, 0, 0);
    checkOutput("b_prod", 1'b1, 1, 0, 0, 0, 0);
    applyStimulus(1, 5, 1, 1, 1, 1, 6, 0, 0);
    checkOutput("b_stall", 1'b1, 0, 1, 1, 0, 0);
    applyStimulus(1, 5, 1, 1, 1, 1, 6, 0, 0);
    checkOutput("b_issue", 1'b1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 1, 0, 1, 5, 0, 0);
      checkOutput("b_sat_prod", 1'b1, 1, 0, 0, 0, (i + 1 > 3) ? 3 : i + 1);
      applyStimulus(1, 5, 1, 1, 1, 1, 6, 0, 0);
      checkOutput("b_sat_stall", 1'b1, 0, 1, 1, 0, (i + 1 > 3) ? 3 : i + 1);
      applyStimulus(1, 5, 1, 1, 1, 1, 6, 0, 0);
      checkOutput("b_sat_issue", 1'b1, 1, 0, 0, 0, (i + 2 > 3) ? 3 : i + 2);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("b_sat_final", 1'b1, 1, 1, 0, 0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
